// File: rtl/osd_bus_arbiter_if.sv
// Handshake and OSD command-port signals shared by osd_bus_arbiter and its environment.
// slave = the arbiter side, master = the requesters/OSD side.
interface osd_bus_arbiter_if;
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_last;
  logic        a_ready;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_last;
  logic        b_ready;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;
  logic [1:0]  grant;
  logic        timeout_err;

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last,
    output a_ready, b_ready, io_osd, io_strobe, io_din, grant, timeout_err
  );

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last,
    input  a_ready, b_ready, io_osd, io_strobe, io_din, grant, timeout_err
  );
endinterface

// File: rtl/osd_bus_arbiter.sv
// Per-packet round-robin arbiter framing two word sources onto the OSD command port.
// Define OSD_TIMEOUT_EN to abort packets whose owner stalls for TIMEOUT cycles.
//
// state  | meaning
// IDLE   | no owner, io_osd low, waiting for a requester
// LOAD   | owner granted, waiting for its next word
// SETUP  | io_din settles one cycle before the strobe
// STROBE | io_strobe high for STROBE_HIGH cycles
// HOLD   | io_strobe low for STROBE_GAP cycles
// CLOSE  | io_osd low for FRAME_GAP cycles so the OSD commits
module osd_bus_arbiter #(
  parameter int STROBE_HIGH = 2,
  parameter int STROBE_GAP  = 2,
  parameter int FRAME_GAP   = 4
`ifdef OSD_TIMEOUT_EN
  , parameter int TIMEOUT   = 1024
`endif
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  osd_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, CLOSE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  timer_q, timer_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] io_din_q, io_din_d;
  logic        io_osd_q, io_osd_d;
  logic        io_strobe_q, io_strobe_d;
  logic        word_last_q, word_last_d;
  logic        last_owner_q, last_owner_d;  // 1 = B owned the previous packet
  logic        sel_valid, sel_last;
  logic [15:0] sel_data;

`ifdef OSD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  assign sel_valid = grant_q[1] ? bus.b_valid : bus.a_valid;
  assign sel_data  = grant_q[1] ? bus.b_data  : bus.a_data;
  assign sel_last  = grant_q[1] ? bus.b_last  : bus.a_last;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    grant_d      = grant_q;
    io_din_d     = io_din_q;
    word_last_d  = word_last_q;
    last_owner_d = last_owner_q;
`ifdef OSD_TIMEOUT_EN
    idle_cnt_d    = '0;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || last_owner_q)) begin
          grant_d = 2'b01;
          state_d = LOAD;
        end else if (bus.b_valid) begin
          grant_d = 2'b10;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          io_din_d    = sel_data;
          word_last_d = sel_last;
          state_d     = SETUP;
        end
`ifdef OSD_TIMEOUT_EN
        else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d       = CLOSE;
          timer_d       = 4'(FRAME_GAP - 1);
          grant_d       = 2'b00;
          last_owner_d  = grant_q[1];
          timeout_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
`endif
      end
      SETUP: begin
        state_d = STROBE;
        timer_d = 4'(STROBE_HIGH - 1);
      end
      STROBE: begin
        if (timer_q == 4'd0) begin
          state_d = HOLD;
          timer_d = 4'(STROBE_GAP - 1);
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      HOLD: begin
        if (timer_q != 4'd0) begin
          timer_d = timer_q - 4'd1;
        end else if (word_last_q) begin
          state_d      = CLOSE;
          timer_d      = 4'(FRAME_GAP - 1);
          grant_d      = 2'b00;
          last_owner_d = grant_q[1];
        end else begin
          state_d = LOAD;
        end
      end
      CLOSE: begin
        if (timer_q == 4'd0) state_d = IDLE;
        else                 timer_d = timer_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Frame and strobe are registered straight from the next state.
    io_osd_d    = state_d inside {LOAD, SETUP, STROBE, HOLD};
    io_strobe_d = (state_d == STROBE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      grant_q      <= '0;
      io_din_q     <= '0;
      io_osd_q     <= 1'b0;
      io_strobe_q  <= 1'b0;
      word_last_q  <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      grant_q      <= grant_d;
      io_din_q     <= io_din_d;
      io_osd_q     <= io_osd_d;
      io_strobe_q  <= io_strobe_d;
      word_last_q  <= word_last_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef OSD_TIMEOUT_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.a_ready   = (state_q == LOAD) && grant_q[0];
  assign bus.b_ready   = (state_q == LOAD) && grant_q[1];
  assign bus.io_osd    = io_osd_q;
  assign bus.io_strobe = io_strobe_q;
  assign bus.io_din    = io_din_q;
  assign bus.grant     = grant_q;

endmodule
